// File: rtl/fix2flt_pkg.sv
// Shared types and constants for the 16-bit fixed to half-precision converter.
package fix2flt_pkg;

  localparam int EXP_BIAS = 15;
  localparam int FIX_W    = 16;
  localparam int MANT_W   = 10;
  localparam int EXP_W    = 5;

  // Exponent of an input whose leading one already sits in bit FIX_W-1.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + FIX_W - 1);

  typedef enum logic [3:0] {
    IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, WR_HI, WR_LO, DONE
  } fix2flt_state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic rd_en;
    logic wr_en;
  } fix2flt_ctrl_t;

  function automatic fix2flt_ctrl_t ctrl_for(fix2flt_state_t s);
    fix2flt_ctrl_t c;
    c.busy  = (s != IDLE) && (s != DONE);
    c.done  = (s == DONE);
    c.rd_en = (s == RD_HI) || (s == RD_LO);
    c.wr_en = (s == WR_HI) || (s == WR_LO);
    return c;
  endfunction

endpackage

// File: rtl/fix2flt_round.sv
// Round-to-nearest-even of a normalised magnitude into a half-precision word,
// including the exponent bump when the mantissa carries out.
module fix2flt_round
  import fix2flt_pkg::*;
(
  input  logic             sign_i,
  input  logic [FIX_W-1:0] mag_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [FIX_W-1:0] result_o
);

  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_sum;
  logic [EXP_W-1:0]  exp_out;
  logic              unused_lead_one;

  // Bit FIX_W-1 is the implicit leading one and is not stored.
  assign unused_lead_one = mag_i[FIX_W-1];
  assign mant     = mag_i[FIX_W-2 -: MANT_W];
  assign guard    = mag_i[FIX_W-2-MANT_W];
  assign sticky   = |mag_i[FIX_W-3-MANT_W:0];
  assign round_up = guard & (sticky | mant[0]);

  // A carry out leaves the mantissa field at zero, so only the exponent moves.
  assign mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign exp_out  = exp_i + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]};
  assign result_o = {sign_i, exp_out, mant_sum[MANT_W-1:0]};

endmodule

// File: rtl/fix2flt_engine.sv
// Memory-mapped 16-bit two's-complement to IEEE half (RNE) converter.
// Define FIX2FLT_FASTNORM_EN for a single-cycle leading-one normaliser.
module fix2flt_engine
  import fix2flt_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] SRC_ADDR = AW'(0),
  parameter logic [AW-1:0] DST_ADDR = AW'(2)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  fix2flt_state_t   state_q, state_d;
  fix2flt_ctrl_t    ctrl_q;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic [FIX_W-1:0] val_q;
  logic [FIX_W-1:0] mag_q;
  logic [FIX_W-1:0] mag_abs;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q;
  logic [FIX_W-1:0] result_q, result_d;
  logic [FIX_W-1:0] round_res;

  // Unsigned negate keeps 0x8000 as 0x8000, which is exactly its magnitude.
  assign mag_abs = val_q[FIX_W-1] ? (~val_q + 16'd1) : val_q;

  fix2flt_round u_round (
    .sign_i   (sign_q),
    .mag_i    (mag_q),
    .exp_i    (exp_q),
    .result_o (round_res)
  );

`ifdef FIX2FLT_FASTNORM_EN
  logic [3:0] lz;
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < FIX_W; i++) begin
      if (mag_q[i]) lz = 4'(FIX_W - 1 - i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RD_HI;
      RD_HI:      state_d = RD_LO;
      RD_LO:      state_d = ABS;
`ifdef FIX2FLT_FASTNORM_EN
      ABS:        state_d = (mag_abs == '0) ? WR_HI : NORM;
      NORM:       state_d = ROUND;
`else
      ABS: begin
        if (mag_abs == '0)        state_d = WR_HI;
        else if (mag_abs[FIX_W-1]) state_d = ROUND;
        else                      state_d = NORM;
      end
      // Leave once the shift being applied this cycle brings the leading one up.
      NORM:       if (mag_q[FIX_W-2]) state_d = ROUND;
`endif
      ROUND:      state_d = WR_HI;
      WR_HI:      state_d = WR_LO;
      WR_LO:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ABS:     result_d = '0;
      ROUND:   result_d = round_res;
      default: result_d = result_q;
    endcase
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      RD_HI: mem_addr_d = SRC_ADDR;
      RD_LO: mem_addr_d = SRC_ADDR + AW'(1);
      WR_HI: begin
        mem_addr_d  = DST_ADDR;
        mem_wdata_d = result_d[15:8];
      end
      WR_LO: begin
        mem_addr_d  = DST_ADDR + AW'(1);
        mem_wdata_d = result_q[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      val_q       <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_for(state_d);
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      result_q    <= result_d;
      case (state_q)
        RD_HI: val_q[15:8] <= mem_rdata;
        RD_LO: val_q[7:0]  <= mem_rdata;
        ABS: begin
          sign_q <= val_q[FIX_W-1];
          mag_q  <= mag_abs;
          exp_q  <= EXP_INIT;
        end
`ifdef FIX2FLT_FASTNORM_EN
        NORM: begin
          mag_q <= mag_q << lz;
          exp_q <= EXP_INIT - {1'b0, lz};
        end
`else
        NORM: begin
          mag_q <= mag_q << 1;
          exp_q <= exp_q - 5'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign mem_rd_en = ctrl_q.rd_en;
  assign mem_wr_en = ctrl_q.wr_en;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fix2flt_engine.sv
// Directed-vector bench for fix2flt_engine with a byte-wide memory model.
// Latencies follow FIX2FLT_FASTNORM_EN when the bench is built with it.
module tb_fix2flt_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, mem_rd_en, mem_wr_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [0:255];
  int         wr_count = 0;
  int         overlap_count = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  fix2flt_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (mem_wr_en) wr_count <= wr_count + 1;
  always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap_count <= overlap_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    int          k;
  } vec_t;

  vec_t vecs [10] = '{
    '{16'h0001, 16'h3C00, 15},
    '{16'hFFFF, 16'hBC00, 15},
    '{16'h8000, 16'hF800, 0},
    '{16'h7FFF, 16'h7800, 1},
    '{16'h0803, 16'h6802, 4},
    '{16'h0801, 16'h6800, 4},
    '{16'h0000, 16'h0000, 0},
    '{16'h0400, 16'h6400, 5},
    '{16'hFFFD, 16'hC200, 14},
    '{16'h0FFF, 16'h6C00, 4}
  };

  function automatic int lat_for(input logic [15:0] din, input int k);
    if (din == 16'h0000) return 6;
`ifdef FIX2FLT_FASTNORM_EN
    return 8;
`else
    return 7 + k;
`endif
  endfunction

  // Latency counts clock edges from the accepting edge through the edge raising done.
  task automatic run_conv(input logic [15:0] din, input logic [15:0] dout,
                          input int lat_exp, input bit repulse);
    int lat;
    int wr_before;
    string tg;
    tg = $sformatf("%04h", din);
    mem[0] = din[15:8];
    mem[1] = din[7:0];
    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    wr_before = wr_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    check({tg, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (repulse && lat == 3) start = 1'b1;
      if (repulse && lat == 4) start = 1'b0;
    end
    check({tg, " done"}, {31'd0, done}, 32'd1);
    check({tg, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tg, " latency"}, lat, lat_exp);
    check({tg, " result"}, {16'd0, mem[2], mem[3]}, {16'd0, dout});
    check({tg, " writes"}, wr_count - wr_before, 2);
    $display("conv in=%04h out=%02h%02h latency=%0d", din, mem[2], mem[3], lat);
    if (repulse) begin
      repeat (3) @(posedge clk);
      #1;
      check({tg, " done_held"}, {31'd0, done}, 32'd1);
      check({tg, " no_restart_writes"}, wr_count - wr_before, 2);
    end
  endtask

  initial begin
    int lat;
    int wr_before;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {18'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata},
          32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_conv(vecs[i].din, vecs[i].dout, lat_for(vecs[i].din, vecs[i].k), 1'b0);

    // Start re-pulsed mid-conversion must not restart or add writes.
    run_conv(16'h0803, 16'h6802, lat_for(16'h0803, 4), 1'b1);

    // Abort inside NORM: outputs clear at once and the destination is untouched.
    mem[0] = 8'h00;
    mem[1] = 8'h01;
    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    wr_before = wr_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    while (lat < 4) begin
      @(posedge clk);
      lat++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {18'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata},
          32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_dst", {16'd0, mem[2], mem[3]}, 32'h0000A55A);
    check("abort_writes", wr_count - wr_before, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_conv(16'h7FFF, 16'h7800, lat_for(16'h7FFF, 1), 1'b0);

    check("rd_wr_overlap", overlap_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fix2flt_engine.md
Name: fix2flt_engine

Overview:
- Hardware converter that reads a 16-bit two's-complement integer from data memory and writes the IEEE-754 half-precision equivalent back to data memory.
- Rounding is round-to-nearest-even (RNE).
- Sits beside the 9-bit core as a memory-mapped accelerator on the same byte-wide data_mem port; it is the reverse path of the float-to-fixed program.
- Uses the same start/done handshake as the core.

Parameters:
- AW, 8, data memory address width
- SRC_ADDR, 8'd0, address of the input MSB; the LSB is at SRC_ADDR+1
- DST_ADDR, 8'd2, address of the output MSB; the LSB is at DST_ADDR+1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  high in DONE; held until the next accepted start
- mem_addr  out  AW  data memory address
- mem_rd_en  out  1  read strobe; read data is combinational, same cycle
- mem_wr_en  out  1  write strobe; write commits at the next rising edge
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - All internal registers are cleared.
  - Reset asserted mid-operation aborts the conversion and performs no partial write; bytes already written stay in memory.
- FSM sequence: IDLE -> RD_HI -> RD_LO -> ABS -> NORM -> ROUND -> WR_HI -> WR_LO -> DONE.
- IDLE/DONE: start=1 moves to RD_HI, clears done and sets busy. start while busy is ignored.
- RD_HI: mem_addr=SRC_ADDR, mem_rd_en=1, capture mem_rdata into val[15:8].
- RD_LO: mem_addr=SRC_ADDR+1, mem_rd_en=1, capture mem_rdata into val[7:0].
- ABS: sign=val[15], mag=sign ? -val : val, computed as 16-bit unsigned so 0x8000 stays 0x8000.
  - Exponent register exp=5'd30.
  - If mag=0, the result is 16'h0000 and the FSM skips to WR_HI.
- NORM: while mag[15]=0, shift mag left by 1 and decrement exp, one shift per cycle (0..15 cycles).
- ROUND: mant=mag[14:5], guard=mag[4], sticky=|mag[3:0].
  - Round up when guard & (sticky | mant[0]).
  - Mantissa carry-out gives mant=0 and exp+1; the maximum reachable exp is 30, so there is no overflow or Inf path.
  - Result = {sign, exp, mant}.
- WR_HI: mem_addr=DST_ADDR, mem_wr_en=1, mem_wdata=result[15:8].
- WR_LO: mem_addr=DST_ADDR+1, mem_wr_en=1, mem_wdata=result[7:0].
- DONE: done=1, busy=0.
- Outputs are registered or decoded from state only. mem_rd_en and mem_wr_en are never asserted together.
- Latency from start acceptance to done rising is 7+k cycles, where k is the NORM shift count; for zero input it is 6 cycles.

Optional Feature:
- Macro FIX2FLT_FASTNORM_EN.
- Defined: NORM takes exactly 1 cycle. A leading-one priority encoder computes k, and the block performs the shift by k and exp=30-k in that cycle.
- Undefined: NORM is the iterative 1-bit-per-cycle shifter.
- Results and memory traffic are bit-identical in both builds; only latency differs.

Decomposition:
- Package fix2flt_pkg holds:
  - state enum fix2flt_state_t;
  - constants EXP_BIAS=15, FIX_W=16, MANT_W=10, EXP_W=5.
- One sub-module fix2flt_round (combinational RNE plus exponent carry), which makes the rounding unit-testable in isolation.
- The FSM, datapath registers and memory sequencing stay in fix2flt_engine.

Test Plan:
- mem[0:1]=00 01, start -> mem[2:3]=3C 00, done after 22 cycles (iterative build), busy low at done.
- mem[0:1]=FF FF -> 0xBC00. mem[0:1]=80 00 -> 0xF800 with no shifts (k=0).
- mem[0:1]=7F FF -> 0x7800 (rounds into the exponent). mem[0:1]=08 03 -> 0x6802 (tie rounds to even, up). mem[0:1]=08 01 -> 0x6800 (tie stays).
- mem[0:1]=00 00 -> 0x0000, done 6 cycles after acceptance. Re-pulse start while busy -> ignored, exactly two writes per transaction.
- Drop reset_n during NORM -> all outputs 0 immediately and mem[2:3] unchanged; a fresh start converts correctly.
- With FIX2FLT_FASTNORM_EN, rerun all vectors -> identical mem[2:3]; latency 8 cycles for every nonzero input.
